// File: rtl/ham1511_stream_decoder.sv
// Two-stage streaming Hamming(15,11) decoder: S1 registers codeword + syndrome,
// S2 registers the corrected data word and flags. Saturating delivery counters.
module ham1511_stream_decoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [14:0]      in_cw,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [10:0]      out_data,
   output logic [3:0]       out_syndrome,
   output logic             out_corrected,
   output logic             out_par_err,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] corr_cnt
);

   // Syndrome bit k covers every position whose 1-based index has bit k set.
   function automatic logic [3:0] calc_syn(input logic [14:0] cw);
      logic [3:0] s;
      s = '0;
      for (int p = 1; p < 16; p++) begin
         for (int k = 0; k < 4; k++) begin
            if (p[k]) s[k] = s[k] ^ cw[p-1];
         end
      end
      return s;
   endfunction

   function automatic logic [10:0] extract(input logic [14:0] c);
      return {c[14], c[13], c[12], c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
   endfunction

   logic             adv1, adv2, out_xfer;
   logic             v1_q, v1_d, v2_q, v2_d;
   logic [14:0]      cw1_q, cw1_d, fixed_cw;
   logic [3:0]       syn1_q, syn1_d, syn2_q, syn2_d;
   logic [10:0]      data2_q, data2_d;
   logic             corr2_q, corr2_d, par2_q, par2_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d, ccnt_q, ccnt_d;

   always_comb begin
      adv2     = ~v2_q | out_ready;
      adv1     = ~v1_q | adv2;
      out_xfer = v2_q & out_ready;
      v1_d     = v1_q;
      cw1_d    = cw1_q;
      syn1_d   = syn1_q;
      v2_d     = v2_q;
      data2_d  = data2_q;
      syn2_d   = syn2_q;
      corr2_d  = corr2_q;
      par2_d   = par2_q;
      wcnt_d   = wcnt_q;
      ccnt_d   = ccnt_q;
      fixed_cw = cw1_q;

      if (adv1) begin
         v1_d = in_valid;
         if (in_valid) begin
            cw1_d  = in_cw;
            syn1_d = calc_syn(in_cw);
         end
      end

      // Perfect code: any nonzero syndrome names the position to invert.
      if (syn1_q != 4'd0) fixed_cw = cw1_q ^ (15'd1 << (syn1_q - 4'd1));

      if (adv2) begin
         v2_d = v1_q;
         if (v1_q) begin
            data2_d = extract(fixed_cw);
            syn2_d  = syn1_q;
            corr2_d = |syn1_q;
            par2_d  = (syn1_q != 4'd0) && ((syn1_q & (syn1_q - 4'd1)) == 4'd0);
         end
      end

      if (clr_cnt) begin
         wcnt_d = '0;
         ccnt_d = '0;
      end else if (out_xfer) begin
         if (wcnt_q != '1) wcnt_d = wcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         if (corr2_q && ccnt_q != '1) ccnt_d = ccnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q    <= 1'b0;
         cw1_q   <= '0;
         syn1_q  <= '0;
         v2_q    <= 1'b0;
         data2_q <= '0;
         syn2_q  <= '0;
         corr2_q <= 1'b0;
         par2_q  <= 1'b0;
         wcnt_q  <= '0;
         ccnt_q  <= '0;
      end else begin
         v1_q    <= v1_d;
         cw1_q   <= cw1_d;
         syn1_q  <= syn1_d;
         v2_q    <= v2_d;
         data2_q <= data2_d;
         syn2_q  <= syn2_d;
         corr2_q <= corr2_d;
         par2_q  <= par2_d;
         wcnt_q  <= wcnt_d;
         ccnt_q  <= ccnt_d;
      end
   end

   assign in_ready      = adv1;
   assign out_valid     = v2_q;
   assign out_data      = data2_q;
   assign out_syndrome  = syn2_q;
   assign out_corrected = corr2_q;
   assign out_par_err   = par2_q;
   assign word_cnt      = wcnt_q;
   assign corr_cnt      = ccnt_q;

endmodule
